// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 definitions for the key decoder: scan codes, prefix FSM
// state encoding, direction nibble bit positions and key-map helpers.
// Optional feature macro: PS2_ARROW_KEYS_EN (arrow keys alias player two).
package ps2_keys_pkg;

   // Player one letter keys
   localparam logic [7:0] SC_W = 8'h1D;
   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_S = 8'h1B;
   localparam logic [7:0] SC_D = 8'h23;
   // Player two letter keys
   localparam logic [7:0] SC_I = 8'h43;
   localparam logic [7:0] SC_J = 8'h3B;
   localparam logic [7:0] SC_K = 8'h42;
   localparam logic [7:0] SC_L = 8'h4B;
   // Prefixes
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   // Extended arrow codes (second byte after E0)
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // Direction nibble bit positions, shared with the datapath direction decode
   localparam int BIT_UP    = 3;
   localparam int BIT_LEFT  = 2;
   localparam int BIT_DOWN  = 1;
   localparam int BIT_RIGHT = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } prefix_state_t;

   // One-hot direction for a player one scan code (zero when unmapped)
   function automatic logic [3:0] map_p1(input logic [7:0] code);
      logic [3:0] m;
      m = 4'b0000;
      case (code)
         SC_W:    m[BIT_UP]    = 1'b1;
         SC_A:    m[BIT_LEFT]  = 1'b1;
         SC_S:    m[BIT_DOWN]  = 1'b1;
         SC_D:    m[BIT_RIGHT] = 1'b1;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // One-hot direction for a player two scan code (zero when unmapped)
   function automatic logic [3:0] map_p2(input logic [7:0] code);
      logic [3:0] m;
      m = 4'b0000;
      case (code)
         SC_I:    m[BIT_UP]    = 1'b1;
         SC_J:    m[BIT_LEFT]  = 1'b1;
         SC_K:    m[BIT_DOWN]  = 1'b1;
         SC_L:    m[BIT_RIGHT] = 1'b1;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // One-hot direction for an extended arrow code (zero when unmapped)
   function automatic logic [3:0] map_arrow(input logic [7:0] code);
      logic [3:0] m;
      m = 4'b0000;
      case (code)
         SC_UP:    m[BIT_UP]    = 1'b1;
         SC_LEFT:  m[BIT_LEFT]  = 1'b1;
         SC_DOWN:  m[BIT_DOWN]  = 1'b1;
         SC_RIGHT: m[BIT_RIGHT] = 1'b1;
         default:  m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_prefix_fsm.sv
// Prefix tracker for the PS/2 byte stream. Follows F0/E0 prefixes, classifies
// each payload byte as a make or a break (plain or extended), and aborts a
// half-finished prefix sequence after TIMEOUT_CYCLES quiet cycles.
module ps2_prefix_fsm
   import ps2_keys_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       make_strobe,
   output logic       break_strobe,
   output logic       ext,
   output logic [7:0] code,
   output logic       seq_abort
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   prefix_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seq_abort_q, seq_abort_d;

   // Next state, timeout counter and payload classification
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      seq_abort_d  = 1'b0;
      make_strobe  = 1'b0;
      break_strobe = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (byte_valid) begin
               if (byte_data == SC_BREAK)    state_d = ST_BRK;
               else if (byte_data == SC_EXT) state_d = ST_EXT;
               else                          make_strobe = 1'b1;
            end
         end
         ST_BRK: begin
            if (byte_valid) begin
               break_strobe = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_EXT: begin
            if (byte_valid) begin
               if (byte_data == SC_BREAK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  make_strobe = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_EXT_BRK: begin
            if (byte_valid) begin
               break_strobe = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Any byte restarts the count (entry into the next prefix state loads 0);
      // a quiet prefix state counts up and gives up at the last count.
      if (state_q != ST_IDLE) begin
         if (byte_valid) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            seq_abort_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State, counter and abort pulse registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         seq_abort_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seq_abort_q <= seq_abort_d;
      end
   end

   assign ext       = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
   assign code      = byte_data;
   assign seq_abort = seq_abort_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: converts set-2 scan bytes into per-player direction
// nibbles. Each key has a held bit (tracks make/break) and a pending bit that
// survives a short tap until the player's direction is consumed.
// Optional feature macro: PS2_ARROW_KEYS_EN (arrow keys alias player two).
module ps2_key_decoder
   import ps2_keys_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       consume1,
   input  logic       consume2,
   output logic [3:0] player_one,
   output logic [3:0] player_two,
   output logic       seq_abort
);

   logic       make_strobe, break_strobe, ext;
   logic [7:0] code;
   logic [3:0] m1, m2;
   logic [3:0] held1_q, held1_d, held2_q, held2_d;
   logic [3:0] pend1_q, pend1_d, pend2_q, pend2_d;
   logic [3:0] player_one_q, player_one_d, player_two_q, player_two_d;

   ps2_prefix_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_prefix_fsm (
      .clk         (clk),
      .resetn      (resetn),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .make_strobe (make_strobe),
      .break_strobe(break_strobe),
      .ext         (ext),
      .code        (code),
      .seq_abort   (seq_abort)
   );

   assign m1 = map_p1(code);
   assign m2 = map_p2(code);

`ifdef PS2_ARROW_KEYS_EN
   logic [3:0] ma;
   logic [3:0] arrow_q, arrow_d;
   assign ma = map_arrow(code);
`endif

   // Held/pending update; a make in the consume cycle wins over the clear
   always_comb begin
      held1_d = held1_q;
      held2_d = held2_q;
      pend1_d = consume1 ? 4'b0000 : pend1_q;
      pend2_d = consume2 ? 4'b0000 : pend2_q;
      if (make_strobe && !ext) begin
         held1_d = held1_d | m1;
         pend1_d = pend1_d | m1;
         held2_d = held2_d | m2;
         pend2_d = pend2_d | m2;
      end
      if (break_strobe && !ext) begin
         held1_d = held1_d & ~m1;
         held2_d = held2_d & ~m2;
      end
`ifdef PS2_ARROW_KEYS_EN
      arrow_d = arrow_q;
      if (make_strobe && ext) begin
         arrow_d = arrow_d | ma;
         pend2_d = pend2_d | ma;
      end
      if (break_strobe && ext) begin
         arrow_d = arrow_d & ~ma;
      end
      player_two_d = held2_d | arrow_d | pend2_d;
`else
      player_two_d = held2_d | pend2_d;
`endif
      player_one_d = held1_d | pend1_d;
   end

   // Key state and registered direction outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         held1_q      <= 4'b0000;
         held2_q      <= 4'b0000;
         pend1_q      <= 4'b0000;
         pend2_q      <= 4'b0000;
         player_one_q <= 4'b0000;
         player_two_q <= 4'b0000;
      end else begin
         held1_q      <= held1_d;
         held2_q      <= held2_d;
         pend1_q      <= pend1_d;
         pend2_q      <= pend2_d;
         player_one_q <= player_one_d;
         player_two_q <= player_two_d;
      end
   end

`ifdef PS2_ARROW_KEYS_EN
   // Arrow-alias held bits, kept apart from the IJKL held bits
   always_ff @(posedge clk) begin
      if (!resetn) arrow_q <= 4'b0000;
      else         arrow_q <= arrow_d;
   end
`endif

   assign player_one = player_one_q;
   assign player_two = player_two_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus random byte
// traffic; a reference model predicts the outputs after each clock edge and
// a monitor compares them with the DUT.
module tb_ps2_key_decoder;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       consume1 = 1'b0;
   logic       consume2 = 1'b0;
   logic [3:0] player_one, player_two;
   logic       seq_abort;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .consume1  (consume1),
      .consume2  (consume2),
      .player_one(player_one),
      .player_two(player_two),
      .seq_abort (seq_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         stamp;
      logic [3:0] p1;
      logic [3:0] p2;
      logic       sa;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: keys described as (player, bit) lookups
   int key_player[byte unsigned];
   int key_bit[byte unsigned];
   int arrow_bit[byte unsigned];
   logic [3:0] m_held1, m_pend1, m_held2, m_pend2, m_arrow;
   bit m_after_f0, m_after_e0;    // seen a break prefix / an extended prefix
   int m_quiet;                   // quiet edges since last byte inside a prefix
   logic m_abort;

   initial begin
      key_player[8'h1D] = 1; key_bit[8'h1D] = 3;
      key_player[8'h1C] = 1; key_bit[8'h1C] = 2;
      key_player[8'h1B] = 1; key_bit[8'h1B] = 1;
      key_player[8'h23] = 1; key_bit[8'h23] = 0;
      key_player[8'h43] = 2; key_bit[8'h43] = 3;
      key_player[8'h3B] = 2; key_bit[8'h3B] = 2;
      key_player[8'h42] = 2; key_bit[8'h42] = 1;
      key_player[8'h4B] = 2; key_bit[8'h4B] = 0;
      arrow_bit[8'h75] = 3; arrow_bit[8'h6B] = 2;
      arrow_bit[8'h72] = 1; arrow_bit[8'h74] = 0;
   end

   function automatic bit arrows_on();
`ifdef PS2_ARROW_KEYS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Apply one clock edge worth of inputs to the model
   task automatic model_edge(input bit rstn, input bit bv, input byte unsigned bd,
                             input bit c1, input bit c2);
      bit in_prefix;
      if (!rstn) begin
         m_held1 = 0; m_pend1 = 0; m_held2 = 0; m_pend2 = 0; m_arrow = 0;
         m_after_f0 = 0; m_after_e0 = 0; m_quiet = 0; m_abort = 0;
         return;
      end
      m_abort = 0;
      if (c1) m_pend1 = 0;
      if (c2) m_pend2 = 0;
      in_prefix = m_after_f0 || m_after_e0;
      if (bv) begin
         m_quiet = 0;
         if (!in_prefix) begin
            if (bd == 8'hF0) m_after_f0 = 1;
            else if (bd == 8'hE0) m_after_e0 = 1;
            else if (key_player.exists(bd)) begin
               if (key_player[bd] == 1) begin
                  m_held1[key_bit[bd]] = 1; m_pend1[key_bit[bd]] = 1;
               end else begin
                  m_held2[key_bit[bd]] = 1; m_pend2[key_bit[bd]] = 1;
               end
            end
         end else if (m_after_e0 && !m_after_f0) begin
            if (bd == 8'hF0) m_after_f0 = 1;
            else begin
               if (arrows_on() && arrow_bit.exists(bd)) begin
                  m_arrow[arrow_bit[bd]] = 1; m_pend2[arrow_bit[bd]] = 1;
               end
               m_after_e0 = 0;
            end
         end else begin
            // break payload (plain or extended)
            if (m_after_e0) begin
               if (arrows_on() && arrow_bit.exists(bd)) m_arrow[arrow_bit[bd]] = 0;
            end else if (key_player.exists(bd)) begin
               if (key_player[bd] == 1) m_held1[key_bit[bd]] = 0;
               else                     m_held2[key_bit[bd]] = 0;
            end
            m_after_f0 = 0; m_after_e0 = 0;
         end
      end else if (in_prefix) begin
         m_quiet++;
         if (m_quiet == TO) begin
            m_after_f0 = 0; m_after_e0 = 0; m_quiet = 0; m_abort = 1;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the predicted outputs for that edge
   task automatic step(input bit rstn, input bit bv, input byte unsigned bd,
                       input bit c1, input bit c2);
      exp_t e;
      @(posedge clk);
      #1;
      resetn = rstn; byte_valid = bv; byte_data = bd;
      consume1 = c1; consume2 = c2;
      model_edge(rstn, bv, bd, c1, c2);
      e.stamp = cyc + 1;
      e.p1 = m_held1 | m_pend1;
      e.p2 = m_held2 | m_arrow | m_pend2;
      e.sa = m_abort;
      exp_q.push_back(e);
   endtask

   task automatic send(input byte unsigned bd);
      step(1, 1, bd, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0);
   endtask

   // Monitor: compare DUT outputs with the prediction for this edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.stamp != cyc || player_one !== e.p1 || player_two !== e.p2 ||
                seq_abort !== e.sa) begin
               n_err++;
               $display("FAIL outputs cyc=%0d: got p1=%b p2=%b abort=%b, required p1=%b p2=%b abort=%b",
                        cyc, player_one, player_two, seq_abort, e.p1, e.p2, e.sa);
            end else begin
               $display("cyc=%0d p1=%b p2=%b abort=%b ok", cyc, player_one, player_two, seq_abort);
            end
         end
      end
   end

   initial begin
      int guard;
      bit bv, c1, c2, rst;
      byte unsigned bd;
      byte unsigned pool[16] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hAA};
      // reset
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);
      // make/break W
      send(8'h1D); idle(1);
      step(1, 0, 8'h00, 1, 0); send(8'hF0); send(8'h1D); idle(2);
      // tap latch D
      send(8'h23); send(8'hF0); send(8'h23); idle(2);
      step(1, 0, 8'h00, 1, 0); idle(1);
      // set/clear collision on K
      send(8'h43); step(1, 1, 8'h42, 0, 1); idle(1);
      step(1, 0, 8'h00, 0, 1); send(8'hF0); send(8'h43); send(8'hF0); send(8'h42);
      step(1, 0, 8'h00, 0, 1); idle(1);
      // prefix timeout, then J as a fresh make
      send(8'hF0); idle(TO + 2); send(8'h3B); idle(1);
      send(8'hE0); idle(TO + 1); send(8'hE0); send(8'hF0); idle(TO + 1);
      // ignored traffic
      send(8'hAA); send(8'hFA); send(8'hE0); send(8'h12);
      send(8'hE0); send(8'hF0); send(8'h12); idle(1);
      // arrow alias vs held letter
      send(8'hE0); send(8'h75); send(8'h43); send(8'hE0); send(8'hF0); send(8'h75);
      step(1, 0, 8'h00, 0, 1); idle(1);
      // reset mid-sequence, then a fresh make
      send(8'hF0); step(0, 0, 8'h00, 0, 0); send(8'h1B); idle(1);
      step(0, 0, 8'h00, 0, 0);
      // random traffic
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         bv  = ($urandom_range(0, 2) == 0);
         bd  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
         c1  = ($urandom_range(0, 5) == 0);
         c2  = ($urandom_range(0, 5) == 0);
         step(!rst, bv, bd, c1, c2);
         if ($urandom_range(0, 99) == 0) idle($urandom_range(TO - 2, TO + 3));
      end
      idle(3);
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d predictions unchecked, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
